// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state codes, coin values and price rule for the vending controller and display stage
package vending_pkg;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'h01,
    ST_GOODS_ONE = 6'h02,
    ST_GOODS_TWO = 6'h04,
    ST_PAYMENT   = 6'h08,
    ST_CHANGE    = 6'h10,
    ST_TEMP      = 6'h20
  } state_t;

  localparam logic [7:0] COIN_1_VAL  = 8'd1;
  localparam logic [7:0] COIN_5_VAL  = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;

  function automatic logic [7:0] price(input logic [2:0] code);
    return {5'd0, code} + 8'd1;
  endfunction

endpackage

// File: rtl/pay_accum.sv
// rtl/pay_accum.sv - sums same-cycle coin pulses onto the running payment, saturates at 255, flags paid >= due
module pay_accum
  import vending_pkg::*;
(
  input  logic [7:0] paid,
  input  logic [7:0] due,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [7:0] paid_next,
  output logic       done
);

  logic [8:0] w_sum;

  // One extra bit keeps the carry so saturation is a single MSB test.
  assign w_sum = {1'b0, paid}
               + (coin_1  ? {1'b0, COIN_1_VAL}  : 9'd0)
               + (coin_5  ? {1'b0, COIN_5_VAL}  : 9'd0)
               + (coin_10 ? {1'b0, COIN_10_VAL} : 9'd0);

  assign paid_next = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign done      = (paid_next >= due);

endmodule

// File: rtl/vending_ctrl_fsm.sv
// rtl/vending_ctrl_fsm.sv - vending transaction FSM: selection, payment with timeout, change/refund and display hold
module vending_ctrl_fsm
  import vending_pkg::*;
#(
  parameter int                CNT_W       = 28,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = 28'd249_999_999,
  parameter logic [CNT_W-1:0] HOLD_MAX    = 28'd99_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_start,
  input  logic       btn_confirm,
  input  logic       btn_pay,
  input  logic       btn_cancel,
  input  logic [2:0] sw_goods,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [5:0] state,
  output logic [2:0] out_goods_high,
  output logic [2:0] out_goods_low,
  output logic [1:0] out_goods_num,
  output logic [7:0] paid,
  output logic [7:0] due,
  output logic [7:0] change,
  output logic       dispense
);

  state_t           r_state;
  logic [2:0]       r_goods_high;
  logic [2:0]       r_goods_low;
  logic [1:0]       r_goods_num;
  logic [7:0]       r_paid;
  logic [7:0]       r_due;
  logic [7:0]       r_change;
  logic             r_dispense;
  logic [CNT_W-1:0] r_timer;

  logic [7:0] w_paid_next;
  logic       w_done;
  logic       w_coin_any;

  assign w_coin_any = coin_1 | coin_5 | coin_10;

  pay_accum u_pay_accum (
    .paid      (r_paid),
    .due       (r_due),
    .coin_1    (coin_1),
    .coin_5    (coin_5),
    .coin_10   (coin_10),
    .paid_next (w_paid_next),
    .done      (w_done)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_goods_high <= 3'd0;
      r_goods_low  <= 3'd0;
      r_goods_num  <= 2'd0;
      r_paid       <= 8'd0;
      r_due        <= 8'd0;
      r_change     <= 8'd0;
      r_dispense   <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_dispense <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_goods_high <= 3'd0;
          r_goods_low  <= 3'd0;
          r_goods_num  <= 2'd0;
          r_paid       <= 8'd0;
          r_due        <= 8'd0;
          r_change     <= 8'd0;
          r_timer      <= '0;
          if (btn_start) r_state <= ST_GOODS_ONE;
        end
        ST_GOODS_ONE: begin
          if (btn_cancel) begin
            r_state <= ST_IDLE;
          end else if (btn_confirm) begin
            r_goods_high <= sw_goods;
            r_goods_num  <= 2'd1;
            r_due        <= price(sw_goods);
            r_state      <= ST_GOODS_TWO;
          end
        end
        ST_GOODS_TWO: begin
          if (btn_cancel) begin
            r_state <= ST_IDLE;
          end else if (btn_confirm) begin
            r_goods_low <= sw_goods;
            r_goods_num <= 2'd2;
            r_due       <= r_due + price(sw_goods);
            r_timer     <= '0;
            r_state     <= ST_PAYMENT;
          end else if (btn_pay) begin
            r_goods_low <= 3'd0;
            r_goods_num <= 2'd1;
            r_timer     <= '0;
            r_state     <= ST_PAYMENT;
          end
        end
        ST_PAYMENT: begin
          // Cancel wins over a coin in the same cycle: that coin is not credited.
          if (btn_cancel) begin
            r_change <= r_paid;
            r_state  <= ST_CHANGE;
          end else if (w_coin_any) begin
            r_paid  <= w_paid_next;
            r_timer <= '0;
            if (w_done) begin
              r_change   <= w_paid_next - r_due;
              r_dispense <= 1'b1;
              r_state    <= ST_CHANGE;
            end
          end else if (r_timer == TIMEOUT_MAX) begin
            r_change <= r_paid;
            r_state  <= ST_CHANGE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CHANGE: begin
          r_timer <= '0;
          r_state <= ST_TEMP;
        end
        ST_TEMP: begin
          if (r_timer == HOLD_MAX) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state          = r_state;
  assign out_goods_high = r_goods_high;
  assign out_goods_low  = r_goods_low;
  assign out_goods_num  = r_goods_num;
  assign paid           = r_paid;
  assign due            = r_due;
  assign change         = r_change;
  assign dispense       = r_dispense;

endmodule

// File: doc/vending_ctrl_fsm.md
Name: vending_ctrl_fsm

Overview:
Main vending controller upstream of the LED/RGB display stage. It walks the customer through item selection, coin payment and change/refund, and owns the one-hot machine state. It also latches the selected goods codes and count that the display stage shows. Inputs are single-cycle, already-debounced button and coin pulses; all outputs are registered.

Parameters:
TIMEOUT_MAX, 28'd249_999_999, idle cycles allowed in PAYMENT before auto-refund (5 s at 50 MHz)
HOLD_MAX, 28'd99_999_999, cycles spent in TEMP before returning to IDLE (2 s)
CNT_W, 28, width of the shared timer counter

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; asynchronous, active-low
btn_start  in  1  pulse: begin a transaction
btn_confirm  in  1  pulse: accept the current selection
btn_pay  in  1  pulse: skip the second item and go to payment
btn_cancel  in  1  pulse: abort the transaction
sw_goods  in  3  goods code from the selection switches (0..7)
coin_1  in  1  pulse: 1-unit coin inserted
coin_5  in  1  pulse: 5-unit coin inserted
coin_10  in  1  pulse: 10-unit coin inserted
state  out  6  one-hot machine state
out_goods_high  out  3  first item code
out_goods_low  out  3  second item code
out_goods_num  out  2  items selected (0, 1 or 2)
paid  out  8  accumulated payment
due  out  8  total price
change  out  8  change or refund amount
dispense  out  1  one-cycle pulse when goods are released

Behaviour:
- State encoding (shared constants): IDLE 6'h01, GOODS_one 6'h02, GOODS_two 6'h04, PAYMENT 6'h08, CHANGE 6'h10, TEMP 6'h20. An illegal state returns to IDLE on the next clock.
- Reset values: state=IDLE; all goods, paid, due and change outputs = 0; dispense=0; timer=0.
- Every input pulse takes effect on the next sys_clk edge, so there is one cycle of latency.
- Price rule: price(code) = code + 1, giving a range of 1..8.
- IDLE:
  - btn_start -> GOODS_one.
  - Clears goods, num, paid, due and change.
- GOODS_one:
  - btn_cancel -> IDLE.
  - Otherwise btn_confirm latches sw_goods into out_goods_high, sets num=1, sets due=price, and moves to GOODS_two.
- GOODS_two:
  - btn_cancel -> IDLE.
  - Otherwise btn_confirm latches sw_goods into out_goods_low, sets num=2, adds price to due, and moves to PAYMENT.
  - Otherwise btn_pay -> PAYMENT with num=1 and out_goods_low=0.
- PAYMENT:
  - Priority order is cancel > coins > timeout.
  - btn_cancel -> CHANGE as a refund: change=paid, no dispense.
  - Coin pulses in the same cycle are summed: paid_next = paid + c1 + 5*c5 + 10*c10, saturating at 255.
  - If paid_next >= due -> CHANGE as a purchase: change = paid_next - due.
  - The timer clears on PAYMENT entry and on any coin cycle, and increments otherwise.
  - Timer == TIMEOUT_MAX -> refund path, identical to cancel.
- CHANGE:
  - Lasts exactly one cycle.
  - dispense=1 for that cycle only on the purchase path; 0 on the refund path.
  - Then -> TEMP with the timer cleared.
- TEMP:
  - Holds goods, paid, due and change stable for display.
  - Timer == HOLD_MAX -> IDLE.
  - Buttons are ignored.
- Inputs outside their listed states are ignored, including btn_start outside IDLE.
- Asynchronous reset mid-transaction forces the reset values immediately; no dispense occurs.
- Arithmetic:
  - Internal sum is 9 bits, then saturated to 8.
  - Maximum due is 16, so change never underflows.

Decomposition:
- Package vending_pkg holds:
  - the six state constants;
  - the coin values 1/5/10;
  - the price function.
- The display stage imports vending_pkg as well.
- Sub-module pay_accum: coin summation, saturation and the paid >= due compare, returning paid_next and a done flag.
- The FSM and the timer stay in vending_ctrl_fsm.

Test Plan:
(All scenarios use TIMEOUT_MAX=20, HOLD_MAX=5.)
1. Reset low mid-PAYMENT with paid=7 -> state=01H and paid=0 immediately, with no clock required; dispense stays 0.
2. Purchase: start; confirm sw=3; confirm sw=1 (due=4+2=6); coin_5; coin_5 -> paid=10, state=10H for 1 cycle, dispense=1, change=4; TEMP for 6 cycles, then IDLE.
3. Single item: start; confirm sw=7; pay (due=8); coin_10 together with coin_1 in the same cycle -> paid=11, change=3, num=1, goods_low=0.
4. Cancel in PAYMENT after coin_5 -> CHANGE with change=5 and dispense=0; cancel asserted together with coin_10 -> coin ignored, change=paid.
5. Timeout: enter PAYMENT, insert coin_1, then no coins for 21 cycles -> refund, change=1; a coin at cycle 15 restarts the 20-cycle count.
6. Saturation: due=16, feed 30 coin_10 pulses via a forced overshoot path (check pay_accum standalone: paid=250 plus coin_10 -> 255, done=1).
